// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory refill responder with fixed latency and line bursts
// Optional feature macro: IMEM_RESP_CRITWORD_EN (critical-word-first beat order with wrap).
// Without it, beats are returned line-aligned (word 0 of the line first).
module imem_responder #(
  parameter int N          = 32,
  parameter int LATENCY    = 3,
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 256,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instrreq,
  input  logic [31:0]   instradr,
  output logic [N-1:0]  instr,
  output logic          val,
  output logic          abort,
  output logic          busy,
  output logic [BW-1:0] beatidx,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, ABORT} state_t;

  localparam logic [BW-1:0] BEAT_MASK = BW'(LINE_WORDS - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);
  localparam logic [3:0]    WAIT_LAST = 4'(LATENCY - 2);

  logic [N-1:0]  mem [DEPTH];
  state_t        state_q, state_d;
  logic [3:0]    latcnt_q;
  logic [BW-1:0] beatcnt_q;
  logic [AW-1:0] word_q;
  logic [AW-1:0] rdaddr;
  logic [N-1:0]  rddata;
  logic [N-1:0]  instr_q;
  logic          badadr;
  logic          accept;
  logic          lastbeat;
  logic          waitdone;
`ifdef IMEM_RESP_CRITWORD_EN
  logic [BW-1:0] off_q;
`endif

  assign badadr   = (instradr[1:0] != 2'b00) || ({2'b00, instradr[31:2]} >= 32'(DEPTH));
  assign accept   = (state_q == IDLE) && instrreq;
  assign lastbeat = (beatcnt_q == LAST_BEAT);
  assign waitdone = (latcnt_q == WAIT_LAST);

  // Beat index: either rotated from the requested word or counted from zero.
`ifdef IMEM_RESP_CRITWORD_EN
  assign beatidx = (beatcnt_q + off_q) & BEAT_MASK;
`else
  assign beatidx = beatcnt_q & BEAT_MASK;
`endif

  // Read is combinational so a same-cycle write only lands after the beat has used the old word.
  assign rdaddr = (word_q & ~LINE_MASK) | AW'(beatidx);
  assign rddata = mem[rdaddr];
  assign instr  = val ? rddata : instr_q;

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    val     = 1'b0;
    abort   = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (instrreq) begin
          if (badadr)            state_d = ABORT;
          else if (LATENCY == 1) state_d = BURST;
          else                   state_d = WAIT;
        end
      end
      WAIT: begin
        if (waitdone) state_d = BURST;
      end
      BURST: begin
        val = 1'b1;
        if (lastbeat) state_d = IDLE;
      end
      ABORT: begin
        abort   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, latency/beat counters and held beat data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      latcnt_q  <= '0;
      beatcnt_q <= '0;
      word_q    <= '0;
      instr_q   <= '0;
`ifdef IMEM_RESP_CRITWORD_EN
      off_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q    <= instradr[AW+1:2];
        latcnt_q  <= '0;
        beatcnt_q <= '0;
`ifdef IMEM_RESP_CRITWORD_EN
        off_q     <= instradr[BW+1:2] & BEAT_MASK;
`endif
      end
      if (state_q == WAIT) latcnt_q <= latcnt_q + 4'd1;
      if (state_q == BURST) begin
        beatcnt_q <= lastbeat ? '0 : beatcnt_q + BW'(1);
        instr_q   <= rddata;
      end
    end
  end

  // Backing store: written at any time, never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule
